// File: rtl/tlb_op_unit.sv
// TLB maintenance op unit: TLBRD/TLBWR/TLBFILL act in the accept cycle, and INVTLB
// walks every entry once. A one-cycle refetch flush follows every TLB modification.
module tlb_op_unit #(
    parameter int TLBNUM    = 16,
    parameter int FILL_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 op,
    input  logic [4:0]                 inv_op,
    input  logic [9:0]                 inv_asid,
    input  logic [18:0]                inv_vppn,
    input  logic [31:0]                pc,
    input  logic [$clog2(TLBNUM)-1:0]  csr_idx,
    input  logic                       csr_ne,
    input  logic                       csr_estat_tlbr,
    input  logic [87:0]                csr_entry,
    output logic [$clog2(TLBNUM)-1:0]  tlb_ridx,
    input  logic [88:0]                tlb_rentry,
    output logic                       tlb_we,
    output logic [$clog2(TLBNUM)-1:0]  tlb_widx,
    output logic [88:0]                tlb_wentry,
    output logic                       rd_we,
    output logic                       rd_ne,
    output logic [87:0]                rd_entry,
    output logic                       flush,
    output logic [31:0]                flush_target
);
    localparam int IDXW = $clog2(TLBNUM);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_FLUSH} state_t;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   cnt, fill_cnt, fill_idx;
    logic [7:0]        lfsr;
    logic [31:0]       pc_q;
    logic [4:0]        inv_op_q;
    logic [9:0]        inv_asid_q;
    logic [18:0]       inv_vppn_q;
    logic              accept, w_e;

    // Fields of the entry currently presented on the read port
    logic              r_e, r_g;
    logic [18:0]       r_vppn;
    logic [5:0]        r_ps;
    logic [9:0]        r_asid;
    logic              asid_eq, va_eq, inv_match;

    assign r_e    = tlb_rentry[88];
    assign r_vppn = tlb_rentry[87:69];
    assign r_ps   = tlb_rentry[68:63];
    assign r_asid = tlb_rentry[62:53];
    assign r_g    = tlb_rentry[52];

    assign in_ready     = (state == S_IDLE) && !rst;
    assign accept       = in_valid && in_ready;
    assign w_e          = csr_estat_tlbr ? 1'b1 : ~csr_ne;
    assign fill_idx     = (FILL_MODE == 1) ? lfsr[IDXW-1:0] : fill_cnt;
    assign rd_ne        = ~r_e;
    assign rd_entry     = r_e ? tlb_rentry[87:0] : 88'd0;
    assign flush_target = pc_q + 32'h4;

    // 2MB pages only compare the upper ten vppn bits
    assign asid_eq = (r_asid == inv_asid_q);
    assign va_eq   = (r_ps == 6'd21) ? (r_vppn[18:9] == inv_vppn_q[18:9])
                                     : (r_vppn == inv_vppn_q);

    always_comb begin
        inv_match = 1'b0;
        case (inv_op_q)
            5'd0, 5'd1: inv_match = 1'b1;
            5'd2:       inv_match = r_g;
            5'd3:       inv_match = !r_g;
            5'd4:       inv_match = !r_g && asid_eq;
            5'd5:       inv_match = !r_g && asid_eq && va_eq;
            5'd6:       inv_match = (r_g || asid_eq) && va_eq;
            default:    inv_match = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        tlb_ridx   = csr_idx;
        tlb_we     = 1'b0;
        tlb_widx   = csr_idx;
        tlb_wentry = {w_e, csr_entry};
        rd_we      = 1'b0;
        flush      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        3'd1: rd_we = 1'b1;
                        3'd2: begin
                            tlb_we    = 1'b1;
                            state_nxt = S_FLUSH;
                        end
                        3'd3: begin
                            tlb_we    = 1'b1;
                            tlb_widx  = fill_idx;
                            state_nxt = S_FLUSH;
                        end
                        3'd4: state_nxt = (inv_op <= 5'd6) ? S_SWEEP : S_FLUSH;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_SWEEP: begin
                tlb_ridx   = cnt;
                tlb_widx   = cnt;
                tlb_wentry = {1'b0, tlb_rentry[87:0]};
                tlb_we     = r_e && inv_match;
                if (cnt == IDXW'(TLBNUM - 1))
                    state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                flush     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Reset wins in its own cycle so a sweep stops writing immediately
        if (rst) begin
            tlb_we = 1'b0;
            rd_we  = 1'b0;
            flush  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            fill_cnt   <= '0;
            lfsr       <= 8'h01;
            pc_q       <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == S_SWEEP) ? cnt + 1'b1 : '0;
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (accept && op == 3'd3)
                fill_cnt <= fill_cnt + 1'b1;
            if (accept) begin
                pc_q       <= pc;
                inv_op_q   <= inv_op;
                inv_asid_q <= inv_asid;
                inv_vppn_q <= inv_vppn;
            end
        end
    end
endmodule
